// File: rtl/mult_csa_pipe.sv
// Pipelined carry-save array multiplier with a valid/ready stream interface and a global stall.
// Define MULT_CSA_SIGNED_EN to add the tc port and Baugh-Wooley two's-complement mode.
module mult_csa_pipe #(
    parameter int WIDTH          = 4,
    parameter int ROWS_PER_STAGE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef MULT_CSA_SIGNED_EN
    input  logic                 tc,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy
);

    localparam int NS = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
`ifdef MULT_CSA_SIGNED_EN
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // One carry-save row: previous sum shifted down one weight, plus carries and new partial product.
    function automatic logic [2*WIDTH-1:0] csa_row(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] c,
                                                   input logic [WIDTH-1:0] pp);
        logic [WIDTH-1:0] x;
        x = s >> 1;
        return {(x & pp) | (x & c) | (pp & c), x ^ pp ^ c};
    endfunction

    function automatic logic [WIDTH-1:0] ripple_add(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        logic             cy;
        cy = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            r[j] = x[j] ^ z[j] ^ cy;
            cy   = (x[j] & z[j]) | (x[j] & cy) | (z[j] & cy);
        end
        return r;
    endfunction

    logic                 stall;
    logic [NS:0]          vld_q;
    logic [WIDTH-1:0]     a_q  [NS];
    logic [WIDTH-1:0]     b_q  [NS];
    logic [WIDTH-1:0]     s_q  [NS];
    logic [WIDTH-1:0]     c_q  [NS];
    logic [WIDTH-1:0]     lo_q [NS];
`ifdef MULT_CSA_SIGNED_EN
    logic                 tc_q [NS+1];
`endif
    logic                 out_vld_q;
    logic [2*WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]     hi_d;

    assign stall     = out_vld_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_vld_q;
    assign y         = y_q;
    assign busy      = (|vld_q) | out_vld_q;

    // S0: input register
    always_ff @(posedge clk) begin
        if (!stall) begin
            a_q[0] <= a;
            b_q[0] <= b;
`ifdef MULT_CSA_SIGNED_EN
            tc_q[0] <= tc;
`endif
        end
    end

    for (genvar k = 0; k < NS; k++) begin : g_stage
        localparam int R0 = k * ROWS_PER_STAGE;
        localparam int R1 = (R0 + ROWS_PER_STAGE < WIDTH) ? R0 + ROWS_PER_STAGE : WIDTH;

        logic [WIDTH-1:0] s_i, c_i, lo_i;
        logic [WIDTH-1:0] s_d, c_d, lo_d, pp;

        if (k == 0) begin : g_first
            assign s_i  = '0;
            assign c_i  = '0;
            assign lo_i = '0;
        end else begin : g_next
            assign s_i  = s_q[k-1];
            assign c_i  = c_q[k-1];
            assign lo_i = lo_q[k-1];
        end

        // CSA stage k: rows R0..R1-1 between registers
        always_comb begin
            s_d  = s_i;
            c_d  = c_i;
            lo_d = lo_i;
            pp   = '0;
            for (int r = R0; r < R1; r++) begin
                pp = a_q[k][r] ? b_q[k] : '0;
`ifdef MULT_CSA_SIGNED_EN
                if (tc_q[k])
                    pp = pp ^ ((r == WIDTH-1) ? ~MSB_ONLY : MSB_ONLY);
`endif
                {c_d, s_d} = csa_row(s_d, c_d, pp);
`ifdef MULT_CSA_SIGNED_EN
                // The 2^WIDTH correction rides in the empty row-0 carry slot of that weight.
                if (tc_q[k] && r == 0)
                    c_d[WIDTH-1] = 1'b1;
`endif
                lo_d[r] = s_d[0];
            end
        end

        always_ff @(posedge clk) begin
            if (!stall) begin
                s_q[k]  <= s_d;
                c_q[k]  <= c_d;
                lo_q[k] <= lo_d;
`ifdef MULT_CSA_SIGNED_EN
                tc_q[k+1] <= tc_q[k];
`endif
            end
        end

        if (k + 1 < NS) begin : g_fwd
            always_ff @(posedge clk) begin
                if (!stall) begin
                    a_q[k+1] <= a_q[k];
                    b_q[k+1] <= b_q[k];
                end
            end
        end
    end

    // Final carry-propagate adder resolves the upper half
    always_comb begin
        hi_d = ripple_add(s_q[NS-1] >> 1, c_q[NS-1]);
`ifdef MULT_CSA_SIGNED_EN
        if (tc_q[NS])
            hi_d[WIDTH-1] = ~hi_d[WIDTH-1];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            out_vld_q <= 1'b0;
            y_q       <= '0;
        end else if (!stall) begin
            vld_q     <= {vld_q[NS-1:0], in_valid};
            out_vld_q <= vld_q[NS];
            if (vld_q[NS])
                y_q <= {hi_d, lo_q[NS-1]};
        end
    end

endmodule

// File: tb/tb_mult_csa_pipe.sv
// Bench for mult_csa_pipe: three parameter sets driven from one directed sequence plus random streams
// checked against an arithmetic reference. Signed cases are built when MULT_CSA_SIGNED_EN is defined.
module tb_mult_csa_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv4 = 0, ir4, ov4, or4 = 1, bz4, tc4 = 0;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [7:0]  y4;
    logic        iv8 = 0, ir8, ov8, or8 = 1, bz8, tc8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] y8;
    logic        iv16 = 0, ir16, ov16, or16 = 1, bz16, tc16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] y16;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    mult_csa_pipe #(.WIDTH(4), .ROWS_PER_STAGE(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
`ifdef MULT_CSA_SIGNED_EN
        .tc(tc4),
`endif
        .out_valid(ov4), .out_ready(or4), .y(y4), .busy(bz4));

    mult_csa_pipe #(.WIDTH(8), .ROWS_PER_STAGE(3)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
`ifdef MULT_CSA_SIGNED_EN
        .tc(tc8),
`endif
        .out_valid(ov8), .out_ready(or8), .y(y8), .busy(bz8));

    mult_csa_pipe #(.WIDTH(16), .ROWS_PER_STAGE(5)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
`ifdef MULT_CSA_SIGNED_EN
        .tc(tc16),
`endif
        .out_valid(ov16), .out_ready(or16), .y(y16), .busy(bz16));

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wid(input int d);
        return (d == 0) ? 4 : (d == 1) ? 8 : 16;
    endfunction

    // Reference: the exact integer product, two's-complement operands when t is set, kept to 2*w bits.
    function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic t);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (t && a[w-1]) sa = sa - (longint'(1) << w);
        if (t && b[w-1]) sb = sb - (longint'(1) << w);
        p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    task automatic set_in(input int d, input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic t, input logic r);
        case (d)
            0: begin iv4 = v; a4 = a[3:0]; b4 = b[3:0]; tc4 = t; or4 = r; end
            1: begin iv8 = v; a8 = a[7:0]; b8 = b[7:0]; tc8 = t; or8 = r; end
            default: begin iv16 = v; a16 = a; b16 = b; tc16 = t; or16 = r; end
        endcase
    endtask

    function automatic logic ov_of(input int d);
        return (d == 0) ? ov4 : (d == 1) ? ov8 : ov16;
    endfunction
    function automatic logic ir_of(input int d);
        return (d == 0) ? ir4 : (d == 1) ? ir8 : ir16;
    endfunction
    function automatic logic bz_of(input int d);
        return (d == 0) ? bz4 : (d == 1) ? bz8 : bz16;
    endfunction
    function automatic logic [31:0] y_of(input int d);
        return (d == 0) ? {24'b0, y4} : (d == 1) ? {16'b0, y8} : y16;
    endfunction

    // Single token with out_ready high; checks acceptance-to-out_valid distance and the product.
    task automatic one_token(input int d, input logic [15:0] a, input logic [15:0] b, input logic t,
                             input logic [31:0] exp, input int lat, input string tag);
        int c0, n;
        set_in(d, 1, a, b, t, 1);
        #1;
        check({tag, "_ready"}, ir_of(d), 1);
        c0 = cyc;
        tick();
        set_in(d, 0, 0, 0, 0, 1);
        n = 0;
        while (!ov_of(d) && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, cyc - c0, lat);
        check({tag, "_y"}, y_of(d), exp);
        tick();
    endtask

    // Streams n operand pairs with random valid/ready duty; a queue holds expected products in order.
    task automatic run_stream(input int d, input int n, input int pv, input int pr, input bit exh,
                              input bit rtc, output int acc_c, output int out_c);
        logic [31:0] q[$];
        logic [15:0] a, b, mask;
        logic        t, r, pend;
        int          sent, got, budget, w;
        w = wid(d);
        mask = 16'((32'd1 << w) - 1);
        q.delete();
        sent = 0; got = 0; budget = 0; pend = 0;
        a = 0; b = 0; t = 0; acc_c = 0; out_c = 0;
        while (1) begin
            r = ($urandom_range(99) < pr);
            if (!pend && sent < n && $urandom_range(99) < pv) begin
                if (exh) begin
                    a = 16'((sent >> w) & int'(mask));
                    b = 16'(sent & int'(mask));
                end else begin
                    a = 16'($urandom) & mask;
                    b = 16'($urandom) & mask;
                end
                t = rtc ? 1'($urandom_range(1)) : 1'b0;
                pend = 1;
            end
            set_in(d, pend, a, b, t, r);
            #1;
            if (ov_of(d) && r) begin
                check($sformatf("d%0d_spurious", w), q.size() > 0, 1);
                if (q.size() > 0) begin
                    check($sformatf("d%0d_y#%0d", w, got), y_of(d), q.pop_front());
                    got++;
                    out_c = cyc;
                end
            end
            if (pend && ir_of(d)) begin
                q.push_back(model(w, a, b, t));
                sent++;
                pend = 0;
                acc_c = cyc;
            end
            if (sent == n && q.size() == 0) break;
            budget++;
            if (budget > n * 20 + 100) begin
                check($sformatf("d%0d_timeout", w), 1, 0);
                break;
            end
            tick();
        end
        check($sformatf("d%0d_count", w), got, n);
    endtask

    initial begin
        int c0, n, ac, oc;
        logic stale;
        bit rtc;
`ifdef MULT_CSA_SIGNED_EN
        rtc = 1;
`else
        rtc = 0;
`endif

        tick();
        tick();
        rst = 0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ov%0d", wid(d)), ov_of(d), 0);
            check($sformatf("rst_busy%0d", wid(d)), bz_of(d), 0);
            check($sformatf("rst_y%0d", wid(d)), y_of(d), 0);
            check($sformatf("rst_ready%0d", wid(d)), ir_of(d), 1);
        end

        one_token(0, 15, 15, 0, 32'hE1, 3, "d4_15x15");
        one_token(0, 0, 9, 0, 0, 3, "d4_0x9");

        run_stream(0, 256, 100, 100, 1, 0, ac, oc);
        check("d4_stream_lat", oc - ac, 3);
        check("d4_busy_last", bz4, 1);
        tick();
        check("d4_busy_drop", bz4, 0);
        check("d4_ov_drop", ov4, 0);

        // 200*250 then 255*1; hold out_ready low for 4 cycles once the first product appears.
        set_in(1, 1, 200, 250, 0, 1);
        #1;
        c0 = cyc;
        tick();
        set_in(1, 1, 255, 1, 0, 1);
        tick();
        set_in(1, 0, 0, 0, 0, 1);
        n = 0;
        while (!ov8 && n < 40) begin
            tick();
            n++;
        end
        check("d8_lat", cyc - c0, 5);
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0, 0, 0);
            #1;
            check("d8_stall_ready", ir8, 0);
            check("d8_stall_ov", ov8, 1);
            check("d8_stall_y", y8, 50000);
            tick();
        end
        set_in(1, 0, 0, 0, 0, 1);
        #1;
        check("d8_release_y", y8, 50000);
        tick();
        check("d8_next_ov", ov8, 1);
        check("d8_next_y", y8, 255);
        tick();
        check("d8_drain_ov", ov8, 0);

        // Reset with three tokens in flight.
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 16'(100 + i), 16'(7 + i), 0, 1);
            tick();
        end
        set_in(1, 0, 0, 0, 0, 1);
        rst = 1;
        tick();
        rst = 0;
        check("rst_mid_ov", ov8, 0);
        check("rst_mid_busy", bz8, 0);
        check("rst_mid_y", y8, 0);
        check("rst_mid_ready", ir8, 1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (ov8 || bz8) stale = 1;
            tick();
        end
        check("rst_mid_stale", stale, 0);

`ifdef MULT_CSA_SIGNED_EN
        one_token(0, 4'h8, 4'h8, 1, 32'h40, 3, "s4_m8xm8");
        one_token(0, 4'h8, 4'h7, 1, 32'hC8, 3, "s4_m8x7");
        one_token(0, 4'h8, 4'h8, 0, 64, 3, "u4_8x8");
        one_token(0, 4'h8, 4'h7, 0, 56, 3, "u4_8x7");
`endif

        run_stream(1, 150, 50, 50, 0, rtc, ac, oc);
        tick();
        run_stream(2, 300, 50, 50, 0, rtc, ac, oc);
        tick();
        check("d16_busy_end", bz16, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
